true_single_port_be_ram: RTL and testbench

TRUE_SINGLE_PORT_BE_RAM -- requirements
Module: true_single_port_be_ram

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_clear_ctrl.sv | 62 ++++++
 rtl/true_single_port_be_ram.sv | 134 +++++++++++++
 tb/tb_true_single_port_be_ram.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared RAM definitions: read-during-write modes, clear FSM states and address sizing.
package ram_pkg;

    typedef enum logic [1:0] {WRITE_FIRST, READ_FIRST, NO_CHANGE} read_mode_t;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    // Number of bits needed to represent value (at least 1).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned res;
        res = 1;
        for (int i = 0; i < 32; i++) begin
            if ((value >> i) != 0) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: walks every word address once, writing zero, starting at reset or on clr_req.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == CLEAR);
        clr_we   = (state_q == CLEAR);
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/true_single_port_be_ram.sv
// Single-port byte-enable RAM with selectable read-during-write mode and optional output register.
// Optional clear engine compiled in by TRUE_SINGLE_PORT_BE_RAM_CLEAR_EN.
module true_single_port_be_ram
    import ram_pkg::*;
#(
    parameter int unsigned RAM_WIDTH = 32,
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned RAM_DEPTH = 1024,
    parameter read_mode_t  READ_MODE = WRITE_FIRST,
    parameter int unsigned OUT_REG   = 0,
    parameter              RAM_STYLE = "block",
    parameter              INIT_FILE = "",
    localparam int unsigned NB       = RAM_WIDTH / BYTE_W,
    localparam int unsigned ADDR_W   = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addra,
    input  logic                 ena,
    input  logic [NB-1:0]        wea,
    input  logic [RAM_WIDTH-1:0] dina,
    output logic [RAM_WIDTH-1:0] douta,
    output logic                 douta_valid,
    input  logic                 clr_req,
    output logic                 busy
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(RAM_DEPTH);

    logic              clr_busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

`ifdef TRUE_SINGLE_PORT_BE_RAM_CLEAR_EN
    ram_clear_ctrl #(
        .DEPTH  (RAM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (clr_busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );
`else
    logic unused_clr_req;
    assign unused_clr_req = clr_req;
    assign clr_busy       = 1'b0;
    assign clr_we         = 1'b0;
    assign clr_addr       = '0;
`endif

    assign busy = clr_busy;

    (* ramstyle = RAM_STYLE *) logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    logic                 in_range;
    logic                 access;
    logic                 rd_fire;
    logic [ADDR_W-1:0]    addr_idx;
    logic [RAM_WIDTH-1:0] rd_word;
    logic [RAM_WIDTH-1:0] rd_q;
    logic                 rd_valid_q;

    assign in_range = ({1'b0, addra} < DEPTH_LIM);
    assign access   = ena & ~clr_busy;
    assign addr_idx = in_range ? addra : '0;
    // NO_CHANGE suppresses the read side entirely on any write.
    assign rd_fire  = access & ~((READ_MODE == NO_CHANGE) & (|wea));

    // Storage only: no reset, per-lane enables so the tools map lanes to byte-write BRAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (access && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) begin
                    mem[addr_idx][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem[addr_idx];
            if (READ_MODE == WRITE_FIRST) begin
                for (int i = 0; i < NB; i++) begin
                    if (wea[i]) begin
                        rd_word[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_q <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [RAM_WIDTH-1:0] out_q;
        logic                 out_valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q       <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= rd_valid_q;
                if (rd_valid_q) begin
                    out_q <= rd_q;
                end
            end
        end

        assign douta       = out_q;
        assign douta_valid = out_valid_q;
    end else begin : g_no_out_reg
        assign douta       = rd_q;
        assign douta_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_true_single_port_be_ram.sv
// Directed bench for true_single_port_be_ram: several parameterisations share one stimulus bus.
module tb_true_single_port_be_ram;
    import ram_pkg::*;

    logic        clk;
    logic        rst;
    logic [9:0]  addra;
    logic        ena;
    logic [3:0]  wea;
    logic [31:0] dina;
    logic        clr_req;

    logic [31:0] dout_wf, dout_rf, dout_nc, dout_or, dout_d6;
    logic        val_wf, val_rf, val_nc, val_or, val_d6;
    logic        busy_wf, busy_rf, busy_nc, busy_or, busy_d6;

    int tests;
    int fails;

    typedef struct {
        logic [9:0]  addr;
        logic        en;
        logic [3:0]  we;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_valid;
    } vec_t;

    vec_t wf_vec [8];

    true_single_port_be_ram u_wf (
        .clk(clk), .rst(rst), .addra(addra), .ena(ena), .wea(wea), .dina(dina),
        .douta(dout_wf), .douta_valid(val_wf), .clr_req(clr_req), .busy(busy_wf)
    );

    true_single_port_be_ram #(.RAM_DEPTH(16), .READ_MODE(READ_FIRST)) u_rf (
        .clk(clk), .rst(rst), .addra(addra[3:0]), .ena(ena), .wea(wea), .dina(dina),
        .douta(dout_rf), .douta_valid(val_rf), .clr_req(clr_req), .busy(busy_rf)
    );

    true_single_port_be_ram #(.RAM_DEPTH(16), .READ_MODE(NO_CHANGE)) u_nc (
        .clk(clk), .rst(rst), .addra(addra[3:0]), .ena(ena), .wea(wea), .dina(dina),
        .douta(dout_nc), .douta_valid(val_nc), .clr_req(clr_req), .busy(busy_nc)
    );

    true_single_port_be_ram #(.RAM_DEPTH(16), .OUT_REG(1)) u_or (
        .clk(clk), .rst(rst), .addra(addra[3:0]), .ena(ena), .wea(wea), .dina(dina),
        .douta(dout_or), .douta_valid(val_or), .clr_req(clr_req), .busy(busy_or)
    );

    true_single_port_be_ram #(.RAM_DEPTH(6)) u_d6 (
        .clk(clk), .rst(rst), .addra(addra[2:0]), .ena(ena), .wea(wea), .dina(dina),
        .douta(dout_d6), .douta_valid(val_d6), .clr_req(clr_req), .busy(busy_d6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] a, input logic e, input logic [3:0] w,
                         input logic [31:0] d);
        addra = a;
        ena   = e;
        wea   = w;
        dina  = d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_wf | busy_rf | busy_nc | busy_or | busy_d6) && n < 3000) begin
            tick();
            n++;
        end
        check("wait_idle", {31'd0, busy_wf | busy_rf | busy_nc | busy_or | busy_d6}, 32'd0);
    endtask

    // Counts consecutive samples with u_rf busy, starting at the current sample.
    task automatic count_busy(output int n);
        n = 0;
        while (busy_rf && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        clr_req = 1'b0;
        drive(10'd0, 1'b0, 4'h0, 32'h0);

        wf_vec[0] = '{10'd5, 1'b1, 4'hF, 32'hAABBCCDD, 32'hAABBCCDD, 1'b1};
        wf_vec[1] = '{10'd5, 1'b1, 4'h5, 32'h11223344, 32'hAA22CC44, 1'b1};
        wf_vec[2] = '{10'd5, 1'b1, 4'h0, 32'h00000000, 32'hAA22CC44, 1'b1};
        wf_vec[3] = '{10'd6, 1'b0, 4'hF, 32'h12345678, 32'hAA22CC44, 1'b0};
        wf_vec[4] = '{10'd6, 1'b1, 4'hF, 32'h000000FF, 32'h000000FF, 1'b1};
        wf_vec[5] = '{10'd5, 1'b1, 4'h0, 32'h00000000, 32'hAA22CC44, 1'b1};
        wf_vec[6] = '{10'd6, 1'b1, 4'h0, 32'h00000000, 32'h000000FF, 1'b1};
        wf_vec[7] = '{10'd6, 1'b1, 4'h2, 32'hFFFF12FF, 32'h000012FF, 1'b1};

        // Reset state
        tick();
        tick();
        check("rst_dout_wf", dout_wf, 32'h0);
        check("rst_valid_wf", {31'd0, val_wf}, 32'd0);
        check("rst_dout_or", dout_or, 32'h0);
        check("rst_valid_or", {31'd0, val_or}, 32'd0);
        rst = 1'b0;
`ifdef TRUE_SINGLE_PORT_BE_RAM_CLEAR_EN
        count_busy(n);
        check("clr_after_rst_cycles", n, 32'd16);
`else
        check("busy_tied_low", {31'd0, busy_wf}, 32'd0);
`endif
        wait_idle();

        // Write-first byte-lane merging
        for (int i = 0; i < 8; i++) begin
            drive(wf_vec[i].addr, wf_vec[i].en, wf_vec[i].we, wf_vec[i].din);
            tick();
            check($sformatf("wf_dout[%0d]", i), dout_wf, wf_vec[i].exp_dout);
            check($sformatf("wf_valid[%0d]", i), {31'd0, val_wf}, {31'd0, wf_vec[i].exp_valid});
        end

        // Read-first and no-change on the same stimulus
        drive(10'd7, 1'b1, 4'hF, 32'h0);
        tick();
        check("nc_init_write_valid", {31'd0, val_nc}, 32'd0);
        drive(10'd7, 1'b1, 4'h0, 32'h0);
        tick();
        check("rf_read0", dout_rf, 32'h0);
        check("nc_read0", dout_nc, 32'h0);
        check("nc_read0_valid", {31'd0, val_nc}, 32'd1);
        drive(10'd7, 1'b1, 4'hF, 32'hDEADBEEF);
        tick();
        check("rf_write_old", dout_rf, 32'h0);
        check("rf_write_valid", {31'd0, val_rf}, 32'd1);
        check("nc_write_hold", dout_nc, 32'h0);
        check("nc_write_valid", {31'd0, val_nc}, 32'd0);
        drive(10'd7, 1'b1, 4'h0, 32'h0);
        tick();
        check("rf_read_new", dout_rf, 32'hDEADBEEF);
        check("nc_read_new", dout_nc, 32'hDEADBEEF);
        drive(10'd7, 1'b0, 4'h0, 32'h0);
        tick();
        check("rf_ena0_hold", dout_rf, 32'hDEADBEEF);
        check("rf_ena0_valid", {31'd0, val_rf}, 32'd0);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_dout_wf", dout_wf, 32'h0);
        check("async_rst_valid_rf", {31'd0, val_rf}, 32'd0);
        check("async_rst_dout_rf", dout_rf, 32'h0);
        tick();
        rst = 1'b0;
`ifdef TRUE_SINGLE_PORT_BE_RAM_CLEAR_EN
        count_busy(n);
        check("clr_rerun_cycles", n, 32'd16);
        wait_idle();
        for (int i = 0; i < 16; i++) begin
            drive(10'(i), 1'b1, 4'h0, 32'h0);
            tick();
            check($sformatf("clr_zero[%0d]", i), dout_rf, 32'h0);
        end
        drive(10'd5, 1'b1, 4'h0, 32'h0);
        tick();
        check("clr_wf_zero", dout_wf, 32'h0);

        // Reset at clear cycle 8 restarts; ena during busy yields no valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(10'd3, 1'b1, 4'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("busy_ena_novalid[%0d]", i), {31'd0, val_rf}, 32'd0);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_clear_busy", {31'd0, busy_rf}, 32'd1);
        tick();
        rst = 1'b0;
        count_busy(n);
        check("clr_restart_cycles", n, 32'd16);
        drive(10'd0, 1'b0, 4'h0, 32'h0);
        wait_idle();

        // clr_req held through the clear is not re-counted
        clr_req = 1'b1;
        tick();
        count_busy(n);
        clr_req = 1'b0;
        check("clr_req_cycles", n, 32'd16);
        wait_idle();
`else
        drive(10'd7, 1'b1, 4'h0, 32'h0);
        tick();
        check("rst_keeps_mem_rf", dout_rf, 32'hDEADBEEF);
        drive(10'd5, 1'b1, 4'h0, 32'h0);
        tick();
        check("rst_keeps_mem_wf", dout_wf, 32'hAA22CC44);
        clr_req = 1'b1;
        drive(10'd5, 1'b0, 4'h0, 32'h0);
        tick();
        clr_req = 1'b0;
        check("clr_req_ignored_busy", {31'd0, busy_wf}, 32'd0);
        drive(10'd5, 1'b1, 4'h0, 32'h0);
        tick();
        check("clr_req_ignored_mem", dout_wf, 32'hAA22CC44);
`endif

        // Output register: two-cycle latency, back-to-back reads
        for (int i = 0; i < 3; i++) begin
            drive(10'(i), 1'b1, 4'hF, 32'h100 + i);
            tick();
        end
        drive(10'd0, 1'b0, 4'h0, 32'h0);
        tick();
        tick();
        drive(10'd0, 1'b1, 4'h0, 32'h0);
        tick();
        check("or_c1_valid", {31'd0, val_or}, 32'd0);
        drive(10'd1, 1'b1, 4'h0, 32'h0);
        tick();
        check("or_c2_valid", {31'd0, val_or}, 32'd1);
        check("or_c2_dout", dout_or, 32'h100);
        drive(10'd2, 1'b1, 4'h0, 32'h0);
        tick();
        check("or_c3_valid", {31'd0, val_or}, 32'd1);
        check("or_c3_dout", dout_or, 32'h101);
        drive(10'd0, 1'b0, 4'h0, 32'h0);
        tick();
        check("or_c4_valid", {31'd0, val_or}, 32'd1);
        check("or_c4_dout", dout_or, 32'h102);
        tick();
        check("or_c5_valid", {31'd0, val_or}, 32'd0);
        check("or_c5_hold", dout_or, 32'h102);

        // Non-power-of-two depth: out-of-range address
        for (int i = 0; i < 6; i++) begin
            drive(10'(i), 1'b1, 4'hF, 32'h60 + i);
            tick();
        end
        drive(10'd7, 1'b1, 4'h0, 32'h0);
        tick();
        check("d6_oor_read", dout_d6, 32'h0);
        check("d6_oor_read_valid", {31'd0, val_d6}, 32'd1);
        drive(10'd5, 1'b1, 4'h0, 32'h0);
        tick();
        drive(10'd7, 1'b1, 4'hF, 32'hFFFFFFFF);
        tick();
        check("d6_oor_write", dout_d6, 32'h0);
        check("d6_oor_write_valid", {31'd0, val_d6}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            drive(10'(i), 1'b1, 4'h0, 32'h0);
            tick();
            check($sformatf("d6_keep[%0d]", i), dout_d6, 32'h60 + i);
        end
        drive(10'd0, 1'b0, 4'h0, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
